// File: rtl/uart_rx_if.sv
// Shared UART definitions and the receiver's line/byte interface.
// The receiver side uses the slave modport; the line driver and consumer use master.
package uart_pkg;
   localparam int DATA_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      DONE  = 3'd4,
      ERROR = 3'd5
   } state_e;
endpackage

interface uart_rx_if;
   logic                           rx;
   logic [uart_pkg::DATA_WIDTH-1:0] rx_data_out;
   logic                           rx_active;
   logic                           done_rx;
   logic                           frame_err;

   modport master (output rx, input rx_data_out, rx_active, done_rx, frame_err);
   modport slave  (input rx, output rx_data_out, rx_active, done_rx, frame_err);
endinterface

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver: 2-FF synchronised input, mid-bit start validation,
// centre sampling of data and stop bits, one-cycle done strobe, held frame-error flag.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 19200
) (
   input logic       clk,
   input logic       rst_n,
   uart_rx_if.slave  bus
);
   localparam int D  = CLK_FREQ / BAUD_RATE;
   localparam int H  = D / 2;
   localparam int CW = (D > 1) ? $clog2(D) : 1;
   localparam logic [CW-1:0] D_LAST = CW'(D - 1);
   localparam logic [CW-1:0] H_LAST = CW'(H - 1);

   logic                  sync1, rx_s;
   state_e                state, state_nx;
   logic [CW-1:0]         clk_div, clk_div_nx;
   logic [2:0]            index_bit, index_nx;
   logic [DATA_WIDTH-1:0] shreg, shreg_nx;
   logic [DATA_WIDTH-1:0] data_q, data_nx;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1     <= 1'b1;
         rx_s      <= 1'b1;
         state     <= IDLE;
         clk_div   <= '0;
         index_bit <= '0;
         shreg     <= '0;
         data_q    <= '0;
      end else begin
         sync1     <= bus.rx;
         rx_s      <= sync1;
         state     <= state_nx;
         clk_div   <= clk_div_nx;
         index_bit <= index_nx;
         shreg     <= shreg_nx;
         data_q    <= data_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      clk_div_nx = clk_div;
      index_nx   = index_bit;
      shreg_nx   = shreg;
      data_nx    = data_q;
      case (state)
         IDLE: begin
            clk_div_nx = '0;
            index_nx   = '0;
            if (!rx_s) state_nx = START;
         end
         START: begin
            // A start bit still low at mid-bit is real; anything else was a glitch
            if (clk_div == H_LAST) begin
               clk_div_nx = '0;
               state_nx   = rx_s ? IDLE : DATA;
            end else begin
               clk_div_nx = clk_div + CW'(1);
            end
         end
         DATA: begin
            if (clk_div == D_LAST) begin
               clk_div_nx          = '0;
               shreg_nx[index_bit] = rx_s;
               if (index_bit == 3'd7) begin
                  index_nx = '0;
                  state_nx = STOP;
               end else begin
                  index_nx = index_bit + 3'd1;
               end
            end else begin
               clk_div_nx = clk_div + CW'(1);
            end
         end
         STOP: begin
            if (clk_div == D_LAST) begin
               clk_div_nx = '0;
               if (rx_s) begin
                  state_nx = DONE;
                  data_nx  = shreg;
               end else begin
                  state_nx = ERROR;
               end
            end else begin
               clk_div_nx = clk_div + CW'(1);
            end
         end
         DONE:    state_nx = IDLE;
         // Hold the error while the line stays low so a break is not read as a new start
         ERROR:   if (rx_s) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign bus.rx_data_out = data_q;
   assign bus.rx_active   = (state == DATA);
   assign bus.done_rx     = (state == DONE);
   assign bus.frame_err   = (state == ERROR);
endmodule
